// File: rtl/seq_calculator.sv
// Clocked four-function calculator: add/sub and min/max in one step, and
// shift-add multiply and restoring divide in WIDTH steps. It uses a start/busy/done handshake.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [1:0]           op_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     rem_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 div_zero_r;
  logic [WIDTH-1:0]     res_hi_r;
  logic [WIDTH-1:0]     res_lo_r;

  logic [2*WIDTH-1:0]   acc_init_s;
  logic [2*WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]     rem_nxt_s;
  logic [WIDTH-1:0]     hi_nxt_s;
  logic [WIDTH-1:0]     lo_nxt_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       shl_s;
  logic [WIDTH:0]       diff_s;
  logic                 q_bit_s;

  // Working-register preload for the accepted operation
  always_comb begin
    acc_init_s = '0;
    case (op)
      2'd0: acc_init_s = {a + b, a - b};
      2'd1: begin
        if (a > b) begin
          acc_init_s = {b, a};
        end else begin
          acc_init_s = {a, b};
        end
      end
      2'd2:    acc_init_s = {{WIDTH{1'b0}}, b};
      2'd3:    acc_init_s = {{WIDTH{1'b0}}, a};
      default: acc_init_s = '0;
    endcase
  end

  // One iteration step; add/sub and min/max pass straight through
  always_comb begin
    acc_nxt_s = acc_r;
    rem_nxt_s = rem_r;
    sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    shl_s     = {rem_r, acc_r[WIDTH-1]};
    diff_s    = shl_s - {1'b0, b_r};
    // Partial remainder never exceeds 2*b-1, so a borrow in the top bit means shl < b
    q_bit_s   = ~diff_s[WIDTH];
    case (op_r)
      2'd2: acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
      2'd3: begin
        acc_nxt_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], q_bit_s};
        if (q_bit_s) begin
          rem_nxt_s = diff_s[WIDTH-1:0];
        end else begin
          rem_nxt_s = shl_s[WIDTH-1:0];
        end
      end
      default: begin
        acc_nxt_s = acc_r;
        rem_nxt_s = rem_r;
      end
    endcase
    if (op_r == 2'd3) begin
      hi_nxt_s = acc_nxt_s[WIDTH-1:0];
      lo_nxt_s = rem_nxt_s;
    end else begin
      hi_nxt_s = acc_nxt_s[2*WIDTH-1:WIDTH];
      lo_nxt_s = acc_nxt_s[WIDTH-1:0];
    end
  end

  // Control FSM, working registers and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      op_r       <= 2'd0;
      a_r        <= '0;
      b_r        <= '0;
      rem_r      <= '0;
      acc_r      <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      res_hi_r   <= '0;
      res_lo_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r    <= op;
            a_r     <= a;
            b_r     <= b;
            acc_r   <= acc_init_s;
            rem_r   <= '0;
            cnt_r   <= op[1] ? CNT_W'(WIDTH - 1) : '0;
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= acc_nxt_s;
          rem_r <= rem_nxt_s;
          if (cnt_r == '0) begin
            res_hi_r   <= hi_nxt_s;
            res_lo_r   <= lo_nxt_s;
            div_zero_r <= (op_r == 2'd3) && (b_r == '0);
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign res_hi   = res_hi_r;
  assign res_lo   = res_lo_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_seq_calculator.sv
// Bench for seq_calculator: an arithmetic reference model is checked every cycle,
// plus directed vectors with literal expectations (WIDTH=8 and WIDTH=4 instances).
module tb_seq_calculator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] res_hi, res_lo;

  logic         start4 = 1'b0;
  logic [1:0]   op4 = 2'd0;
  logic [3:0]   a4 = 4'd0;
  logic [3:0]   b4 = 4'd0;
  logic         busy4, done4, div_zero4;
  logic [3:0]   res_hi4, res_lo4;

  int n_checks = 0;
  int n_fail = 0;

  seq_calculator #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .div_zero(div_zero)
  );

  seq_calculator #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .res_hi(res_hi4), .res_lo(res_lo4), .div_zero(div_zero4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {div_zero, hi, lo} from plain arithmetic
  function automatic logic [2*W:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
    logic [2*W-1:0] prod;
    logic [W-1:0]   s, d;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    s = x + y;
    d = x - y;
    case (o)
      2'd0:    return {1'b0, s, d};
      2'd1:    return {1'b0, (x < y) ? x : y, (x > y) ? x : y};
      2'd2:    return {1'b0, prod};
      default: begin
        if (y == '0) return {1'b1, {W{1'b1}}, x};
        else return {1'b0, x / y, x % y};
      end
    endcase
  endfunction

  // Model: pending result released after 1 or W edges
  int           m_left;
  logic         m_busy, m_done, m_dz, p_dz;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          {p_dz, p_hi, p_lo} <= ref_result(op, a, b);
          m_left <= (op < 2'd2) ? 1 : W;
          m_busy <= 1'b1;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_dz <= p_dz;
          m_done <= 1'b1; m_busy <= 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("res_hi", res_hi, m_hi);
    check("res_lo", res_lo, m_lo);
    check("div_zero", div_zero, m_dz);
  end

  task automatic drive_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        return;
      end
    end
    n_checks++; n_fail++;
    $display("FAIL wait_done: got no done, expected done within 40 cycles");
  endtask

  task automatic run_lit(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int exp_lat, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input logic edz);
    int lat;
    drive_op(o, x, y);
    wait_done(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_hi"}, res_hi, eh);
    check({name, "_lo"}, res_lo, el);
    check({name, "_dz"}, div_zero, edz);
  endtask

  initial begin
    int lat, ndone;
    logic prev;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_hi", res_hi, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_lit("add_sub", 2'd0, 8'd200, 8'd100, 1, 8'd44, 8'd100, 1'b0);

    // Multiply with disturbed inputs and a stray start mid-run
    drive_op(2'd2, 8'd255, 8'd255);
    @(negedge clk);
    a = 8'd3; b = 8'd5; start = 1'b1; op = 2'd0;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 3; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
    check("mul_latency", lat, 8);
    check("mul_hi", res_hi, 8'hFE);
    check("mul_lo", res_lo, 8'h01);
    @(negedge clk);
    check("mul_hold_hi", res_hi, 8'hFE);

    run_lit("div", 2'd3, 8'd200, 8'd7, 8, 8'd28, 8'd4, 1'b0);
    run_lit("div0", 2'd3, 8'd13, 8'd0, 8, 8'hFF, 8'd13, 1'b1);
    run_lit("minmax_eq", 2'd1, 8'd9, 8'd9, 1, 8'd9, 8'd9, 1'b0);
    run_lit("div_exact", 2'd3, 8'd255, 8'd255, 8, 8'd1, 8'd0, 1'b0);
    run_lit("minmax_gt", 2'd1, 8'd250, 8'd17, 1, 8'd17, 8'd250, 1'b0);

    // Held start: an operation every 2 cycles, single-cycle done pulses
    start = 1'b1; op = 2'd1; a = 8'd3; b = 8'd10;
    ndone = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (prev && done) begin
        n_checks++; n_fail++;
        $display("FAIL done_width: got 2-cycle done, expected 1-cycle pulse");
      end
      prev = done;
    end
    start = 1'b0;
    check("held_start_dones", ndone, 5);
    check("held_hi", res_hi, 8'd3);
    check("held_lo", res_lo, 8'd10);

    // Asynchronous reset during a multiply
    drive_op(2'd2, 8'd15, 8'd15);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_hi", res_hi, 8'd0);
    check("arst_lo", res_lo, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("arst_no_done", ndone, 0);

    // WIDTH=4 instance
    start4 = 1'b1; op4 = 2'd3; a4 = 4'd15; b4 = 4'd4;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (done4) lat = i;
    end
    check("w4_div_latency", lat, 4);
    check("w4_div_hi", res_hi4, 4'd3);
    check("w4_div_lo", res_lo4, 4'd3);
    start4 = 1'b1; op4 = 2'd2; a4 = 4'd15; b4 = 4'd15;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (done4) lat = i;
    end
    check("w4_mul_latency", lat, 4);
    check("w4_mul_prod", {res_hi4, res_lo4}, 8'hE1);
    check("w4_mul_dz", div_zero4, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
